// File: rtl/sopc_bus_pkg.sv
// rtl/sopc_bus_pkg.sv - shared types and limits for the SOPC memory arbiter
package sopc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_WAIT    = 15;

  // Index/counter widths never collapse to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
// ARB_FIXED_PRIO_EN: lowest index wins and the pointer input is dropped.
module rr_arbiter
  import sopc_bus_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        valid_o  = 1'b1;
      end
    end
  end
`else
  // Search order is ptr+1, ptr+2, ... so the last winner is visited last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_o && req_i[i] && (i == (int'(ptr_i) + k) % N)) begin
          gnt_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
          valid_o  = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/sopc_mem_arbiter.sv
// rtl/sopc_mem_arbiter.sv - N-master arbiter in front of one synchronous single-port RAM
// ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module sopc_mem_arbiter
  import sopc_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic                            mem_ce,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W/8-1:0]             mem_sel,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata
);

  localparam int IDX_W = clog2_min1(NUM_MASTERS);
  localparam int CNT_W = clog2_min1(WAIT_STATES + 1);
  localparam int SEL_W = DATA_W / 8;

  arb_state_e               state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [NUM_MASTERS-1:0]   gnt_q;
  logic [NUM_MASTERS-1:0]   ack_q;
  logic                     xfer_we_q;
  logic [DATA_W-1:0]        rdata_q;
  logic                     ce_q;
  logic                     we_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [SEL_W-1:0]         sel_q;
  logic [DATA_W-1:0]        wdata_q;

  logic [NUM_MASTERS-1:0]   arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_valid;

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]         ptr_q;
  logic [IDX_W-1:0]         g_q;
`endif

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (m_req),
`ifndef ARB_FIXED_PRIO_EN
    .ptr_i   (ptr_q),
`endif
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      xfer_we_q <= 1'b0;
      rdata_q   <= '0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q     <= IDX_W'(NUM_MASTERS - 1);
      g_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          // The granted request is captured here; later master changes are ignored.
          if (arb_valid) begin
            gnt_q     <= arb_gnt;
            cnt_q     <= CNT_W'(WAIT_STATES);
            xfer_we_q <= m_we[arb_idx];
            ce_q      <= 1'b1;
            we_q      <= m_we[arb_idx];
            addr_q    <= m_addr[arb_idx*ADDR_W +: ADDR_W];
            sel_q     <= m_sel[arb_idx*SEL_W +: SEL_W];
            wdata_q   <= m_wdata[arb_idx*DATA_W +: DATA_W];
`ifndef ARB_FIXED_PRIO_EN
            g_q       <= arb_idx;
`endif
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            ack_q   <= gnt_q;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          ack_q <= '0;
          if (!xfer_we_q) begin
            rdata_q <= mem_rdata;
          end
`ifndef ARB_FIXED_PRIO_EN
          ptr_q   <= g_q;
`endif
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM data arrives in the ack cycle, so it bypasses the holding register there.
  assign m_rdata   = (state_q == ST_RESP && !xfer_we_q) ? mem_rdata : rdata_q;
  assign m_ack     = ack_q;
  assign mem_ce    = ce_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_sel   = sel_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// tb/tb_sopc_mem_arbiter.sv - directed checks of sopc_mem_arbiter at WAIT_STATES 1, 0 and 15
module tb_sopc_mem_arbiter;

  logic        clk;
  logic        rst;

  logic [1:0]  req_s   [3];
  logic [1:0]  we_s    [3];
  logic [63:0] addr_s  [3];
  logic [7:0]  sel_s   [3];
  logic [63:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic [1:0]  ack_s   [3];
  logic        mce_s   [3];
  logic        mwe_s   [3];
  logic [31:0] maddr_s [3];
  logic [3:0]  msel_s  [3];
  logic [31:0] mwdata_s[3];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] ram_init(input int i);
    if (i == 'h10) return 32'hDEADBEEF;
    if (i == 'h20) return 32'h11223344;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int WS = (k == 0) ? 1 : ((k == 1) ? 0 : 15);
    logic [31:0] ram [256];
    logic [31:0] mrdata;

    sopc_mem_arbiter #(
      .NUM_MASTERS (2),
      .ADDR_W      (32),
      .DATA_W      (32),
      .WAIT_STATES (WS)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m_req     (req_s[k]),
      .m_we      (we_s[k]),
      .m_addr    (addr_s[k]),
      .m_sel     (sel_s[k]),
      .m_wdata   (wdata_s[k]),
      .m_rdata   (rdata_s[k]),
      .m_ack     (ack_s[k]),
      .mem_ce    (mce_s[k]),
      .mem_we    (mwe_s[k]),
      .mem_addr  (maddr_s[k]),
      .mem_sel   (msel_s[k]),
      .mem_wdata (mwdata_s[k]),
      .mem_rdata (mrdata)
    );

    always @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
        mrdata <= '0;
      end else if (mce_s[k]) begin
        if (mwe_s[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (msel_s[k][b]) ram[maddr_s[k][7:0]][8*b +: 8] <= mwdata_s[k][8*b +: 8];
          end
        end else begin
          mrdata <= ram[maddr_s[k][7:0]];
        end
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_xfer(input int k, input int m, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    lat = -1;
    rd  = 32'hxxxxxxxx;
    we_s[k][m]              = w;
    addr_s[k][m*32 +: 32]   = a;
    sel_s[k][m*4 +: 4]      = s;
    wdata_s[k][m*32 +: 32]  = d;
    req_s[k][m]             = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ack_s[k][m]) begin
        lat = c;
        rd  = rdata_s[k];
        break;
      end
    end
    req_s[k][m] = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          gseq[4];
    logic [31:0] gdat[4];
    int          gt[4];
    int          n;
    int          eg;
    logic [1:0]  any_ack;

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_s[k] = '0; we_s[k] = '0; addr_s[k] = '0; sel_s[k] = '0; wdata_s[k] = '0;
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();

    chk("rst_ack",   32'(ack_s[0]), 32'h0);
    chk("rst_ce",    32'(mce_s[0]), 32'h0);
    chk("rst_addr",  maddr_s[0],    32'h0);
    chk("rst_rdata", rdata_s[0],    32'h0);

    // Reset in the middle of an access
    we_s[0] = 2'b00; sel_s[0] = 8'hFF; addr_s[0][63:32] = 32'h10; req_s[0] = 2'b10;
    tick();
    chk("t1_ce_access", 32'(mce_s[0]), 32'h1);
    tick();
    rst = 1'b0;
    #1;
    chk("t1_ce_async",   32'(mce_s[0]), 32'h0);
    chk("t1_addr_async", maddr_s[0],    32'h0);
    chk("t1_ack_async",  32'(ack_s[0]), 32'h0);
    req_s[0] = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    any_ack = 2'b00;
    repeat (8) begin
      tick();
      any_ack |= ack_s[0];
    end
    chk("t1_no_ack_after", 32'(any_ack), 32'h0);

    // Single read, cycle by cycle
    we_s[0] = 2'b00; addr_s[0][63:32] = 32'h10; req_s[0] = 2'b10;
    tick();
    chk("t2_c1_ce",   32'(mce_s[0]), 32'h1);
    chk("t2_c1_addr", maddr_s[0],    32'h10);
    chk("t2_c1_we",   32'(mwe_s[0]), 32'h0);
    tick();
    chk("t2_c2_ce",  32'(mce_s[0]), 32'h1);
    chk("t2_c2_ack", 32'(ack_s[0]), 32'h0);
    tick();
    chk("t2_c3_ack",   32'(ack_s[0]), 32'h2);
    chk("t2_c3_rdata", rdata_s[0],    32'hDEADBEEF);
    chk("t2_c3_ce",    32'(mce_s[0]), 32'h0);
    req_s[0] = 2'b00;
    tick();
    chk("t2_c4_ack",  32'(ack_s[0]), 32'h0);
    chk("t2_c4_hold", rdata_s[0],    32'hDEADBEEF);

    // Byte write then read back
    do_xfer(0, 0, 1'b1, 32'h20, 4'b0100, 32'h00AB0000, rd, lat);
    chk("t3_wr_lat",   32'(lat), 32'd3);
    chk("t3_wr_rhold", rd,       32'hDEADBEEF);
    do_xfer(0, 0, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    chk("t3_rd_data",  rd,       32'h11AB3344);

    // Contention from a fresh reset
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    we_s[0] = 2'b00; sel_s[0] = 8'hFF; addr_s[0] = {32'h31, 32'h30};
    for (int i = 0; i < 4; i++) begin gseq[i] = -1; gdat[i] = '0; gt[i] = 0; end
    n = 0;
    req_s[0] = 2'b11;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (ack_s[0] != 2'b00) begin
        gseq[n] = ack_s[0][1] ? 1 : 0;
        gdat[n] = rdata_s[0];
        gt[n]   = c;
        n++;
      end
    end
    req_s[0] = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = i % 2;
`endif
      chk($sformatf("t4_grant%0d", i), 32'(gseq[i]), 32'(eg));
      chk($sformatf("t4_data%0d", i),  gdat[i],      ram_init('h30 + eg));
    end
    chk("t4_spacing", 32'(gt[1] - gt[0]), 32'd4);

    // Lone requester is regranted every 3+WS cycles
    for (int i = 0; i < 4; i++) gt[i] = 0;
    n = 0;
    req_s[0] = 2'b10;
    for (int c = 0; c < 40 && n < 2; c++) begin
      tick();
      if (ack_s[0][1]) begin
        gt[n] = c;
        n++;
      end
    end
    req_s[0] = 2'b00;
    tick();
    chk("lone_count",    32'(n),             32'd2);
    chk("lone_interval", 32'(gt[1] - gt[0]), 32'd4);

    // Master 0 drops its request mid-access
    for (int i = 0; i < 4; i++) begin gseq[i] = -1; gdat[i] = '0; end
    n = 0;
    addr_s[0] = {32'h41, 32'h40};
    req_s[0] = 2'b11;
    tick();
    req_s[0][0] = 1'b0;
    addr_s[0][31:0] = 32'hFF;
    tick();
    chk("t5_latched_addr", maddr_s[0], 32'h40);
    for (int c = 0; c < 30 && n < 2; c++) begin
      if (ack_s[0] != 2'b00) begin
        gseq[n] = ack_s[0][1] ? 1 : 0;
        gdat[n] = rdata_s[0];
        if (ack_s[0][1]) req_s[0][1] = 1'b0;
        n++;
      end
      tick();
    end
    req_s[0] = 2'b00;
    tick();
    chk("t5_first",       32'(gseq[0]), 32'd0);
    chk("t5_first_data",  gdat[0],      ram_init('h40));
    chk("t5_second",      32'(gseq[1]), 32'd1);
    chk("t5_second_data", gdat[1],      ram_init('h41));

    // Wait-state sweep
    do_xfer(1, 0, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("ws0_rd_lat",  32'(lat), 32'd2);
    chk("ws0_rd_data", rd,       32'hDEADBEEF);
    do_xfer(1, 1, 1'b1, 32'h50, 4'hF, 32'hCAFEF00D, rd, lat);
    chk("ws0_wr_lat",  32'(lat), 32'd2);
    do_xfer(1, 0, 1'b0, 32'h50, 4'hF, 32'h0, rd, lat);
    chk("ws0_rb_data", rd,       32'hCAFEF00D);

    do_xfer(2, 1, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
    chk("ws15_rd_lat",  32'(lat), 32'd17);
    chk("ws15_rd_data", rd,       32'hDEADBEEF);
    do_xfer(2, 0, 1'b1, 32'h51, 4'b0001, 32'h000000EE, rd, lat);
    chk("ws15_wr_lat",  32'(lat), 32'd17);
    do_xfer(2, 1, 1'b0, 32'h51, 4'hF, 32'h0, rd, lat);
    chk("ws15_rb_data", rd,       32'hC0DE00EE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
